systolic_feeder: RTL

- Upstream stage of the NxN systolic array.
- Accepts one A/B operand tile over a valid/ready load interface and buffers it locally.
- Streams the tile diagonally skewed into the array's west edge (rows) and north edge (columns) while asserting the array's process enable.
- Signals completion once the last partial product has reached PE[N-1][N-1].

---
 rtl/systolic_feeder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads one NxN int8 A/B operand tile over a valid/ready
// interface, then streams it diagonally skewed into the west (rows) and
// north (columns) edges of an NxN systolic array, pulsing o_done once the
// last operands have reached PE[N-1][N-1].
//
// Parameters:
//   N             array dimension (N >= 2)
// Ports:
//   i_clk         clock, rising edge
//   i_arst_n      asynchronous reset, active-low
//   i_valid       load beat valid
//   o_ready       feeder can accept a load beat
//   i_aRow        beat k: byte j = A[k][j]
//   i_bCol        beat k: byte j = B[j][k]
//   o_row         skewed west-edge data, byte i -> array row i
//   o_col         skewed north-edge data, byte j -> array column j
//   o_doProcess   array process enable
//   o_busy        high while streaming
//   o_done        one-cycle pulse when the tile has drained
// Optional (macro SYSTOLIC_FEEDER_PERF_CNT_EN):
//   o_tileCount   completed tiles, saturating
//   o_stallCycles idle cycles inside a partial load, saturating
module systolic_feeder #(
    parameter int unsigned N = 16
) (
    input  logic           i_clk,
    input  logic           i_arst_n,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [N*8-1:0] i_aRow,
    input  logic [N*8-1:0] i_bCol,
    output logic [N*8-1:0] o_row,
    output logic [N*8-1:0] o_col,
    output logic           o_doProcess,
    output logic           o_busy,
    output logic           o_done
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]    o_tileCount,
    output logic [31:0]    o_stallCycles
`endif
);

    localparam int unsigned DW = N * 8;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW = $clog2(N) + 1;
    localparam int unsigned TW = $clog2(3 * N) + 1;

    localparam logic [BW-1:0] BEAT_LAST = BW'(N - 1);
    localparam logic [TW-1:0] T_LAST    = TW'(3 * N - 3);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [TW-1:0] t_q, t_d;
    logic [TW-1:0] t_src;
    logic          emit;
    logic [DW-1:0] row_d, col_d;
    logic          dop_d, busy_d, done_d, ready_d;
    logic          take;

    logic [7:0] buf_a [N][N];
    logic [7:0] buf_b [N][N];

    // o_ready is only high in IDLE, so a transfer implies the load state
    assign take = i_valid && o_ready;

    // Tile buffer; contents are don't-care after reset
    always_ff @(posedge i_clk) begin
        if (take) begin
            for (int unsigned j = 0; j < N; j++) begin
                buf_a[beat_q[IW-1:0]][IW'(j)] <= i_aRow[8*j +: 8];
                buf_b[IW'(j)][beat_q[IW-1:0]] <= i_bCol[8*j +: 8];
            end
        end
    end

    // Next state, counters and next registered outputs
    always_comb begin
        int d;
        d       = 0;
        state_d = state_q;
        beat_d  = beat_q;
        t_d     = t_q;
        t_src   = '0;
        emit    = 1'b0;
        row_d   = '0;
        col_d   = '0;
        dop_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (take) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BEAT_LAST) begin
                        // t=0 only needs element [0][0] from beat 0 (already stored)
                        state_d = S_STREAM;
                        t_d     = '0;
                        t_src   = '0;
                        emit    = 1'b1;
                        ready_d = 1'b0;
                        dop_d   = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (t_q == T_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    t_d    = t_q + TW'(1);
                    t_src  = t_q + TW'(1);
                    emit   = 1'b1;
                    dop_d  = 1'b1;
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                beat_d  = '0;
                t_d     = '0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
                t_d     = '0;
                ready_d = 1'b1;
            end
        endcase

        // Diagonal skew: lane i shows element (t - i) of its row/column
        if (emit) begin
            for (int unsigned i = 0; i < N; i++) begin
                d = int'(t_src) - int'(i);
                if (d >= 0 && d < int'(N)) begin
                    row_d[8*i +: 8] = buf_a[IW'(i)][IW'(d)];
                    col_d[8*i +: 8] = buf_b[IW'(d)][IW'(i)];
                end
            end
        end
    end

    // State, counters and output registers
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            t_q         <= '0;
            o_row       <= '0;
            o_col       <= '0;
            o_doProcess <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_ready     <= 1'b1;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            t_q         <= t_d;
            o_row       <= row_d;
            o_col       <= col_d;
            o_doProcess <= dop_d;
            o_busy      <= busy_d;
            o_done      <= done_d;
            o_ready     <= ready_d;
        end
    end

`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
    // Saturating tile and load-stall counters
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_tileCount   <= '0;
            o_stallCycles <= '0;
        end else begin
            if (state_q == S_DONE && o_tileCount != '1)
                o_tileCount <= o_tileCount + 32'd1;
            if (state_q == S_IDLE && beat_q != '0 && !i_valid && o_stallCycles != '1)
                o_stallCycles <= o_stallCycles + 32'd1;
        end
    end
`endif

endmodule
